// File: rtl/clock_pkg.sv
// clock_pkg: shared constants for the digital clock board.
// Contents:
//   BTN_0..BTN_3, BTN_MODE  button channel indices
//   DEBOUNCE_10MS, LONG_1S,  default cycle counts at CLK_HZ
//   REPEAT_200MS
//   hold_state_t            per-button hold FSM encodings
package clock_pkg;
   localparam int CLK_HZ        = 50_000_000;
   localparam int BTN_0         = 0;
   localparam int BTN_1         = 1;
   localparam int BTN_2         = 2;
   localparam int BTN_3         = 3;
   localparam int BTN_MODE      = BTN_3;
   localparam int DEBOUNCE_10MS = CLK_HZ / 100;
   localparam int LONG_1S       = CLK_HZ;
   localparam int REPEAT_200MS  = CLK_HZ / 5;
   typedef enum logic [1:0] {
      HOLD_IDLE   = 2'b00,
      HOLD_HELD   = 2'b01,
      HOLD_REPEAT = 2'b10
   } hold_state_t;
endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button channel with a synchroniser, a debouncer and a hold FSM.
// Ports:
//   clk, reset  clock and synchronous active-low reset
//   i_raw       raw asynchronous pin, 0 = pressed
//   o_level     debounced level, 0 = pressed, idle 1
//   o_press     one-cycle pulse when the level goes to 0
//   o_release   one-cycle pulse when the level goes to 1
//   o_long      one-cycle pulse LONG_CYC cycles after o_press
//   o_repeat    one-cycle pulse every REPEAT_CYC cycles after o_long while held
module btn_channel
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEBOUNCE_10MS,
   parameter int LONG_CYC     = LONG_1S,
   parameter int REPEAT_CYC   = REPEAT_200MS
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int HW = $clog2(LONG_CYC + 1);
   localparam int RW = $clog2(REPEAT_CYC + 1);

   logic [1:0]    r_sync;
   logic          r_level;
   logic [DW-1:0] r_db_cnt;
   hold_state_t   r_state;
   hold_state_t   w_state_nxt;
   logic [HW-1:0] r_hold_cnt;
   logic [HW-1:0] w_hold_nxt;
   logic [RW-1:0] r_rep_cnt;
   logic [RW-1:0] w_rep_nxt;
   logic          r_press;
   logic          r_release;
   logic          r_long;
   logic          r_repeat;
   logic          w_long_nxt;
   logic          w_repeat_nxt;
   logic          w_diff;
   logic          w_flip;
   logic          w_press;
   logic          w_release;

   // The counter tracks differing cycles already seen. The flip needs one more
   // differing cycle beyond a full count, which gives the DEBOUNCE_CYC+2 latency.
   assign w_diff    = r_sync[1] ^ r_level;
   assign w_flip    = w_diff && (r_db_cnt == DW'(DEBOUNCE_CYC));
   assign w_press   = w_flip && r_level;
   assign w_release = w_flip && !r_level;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync    <= 2'b11;
         r_level   <= 1'b1;
         r_db_cnt  <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], i_raw};
         r_db_cnt  <= (w_diff && !w_flip) ? r_db_cnt + DW'(1) : '0;
         r_level   <= r_level ^ w_flip;
         r_press   <= w_press;
         r_release <= w_release;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= HOLD_IDLE;
         r_hold_cnt <= '0;
         r_rep_cnt  <= '0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rep_cnt  <= w_rep_nxt;
         r_long     <= w_long_nxt;
         r_repeat   <= w_repeat_nxt;
      end
   end

   // A release is checked before the long and repeat terminal counts, so it
   // suppresses any long or repeat pulse due in the same cycle.
   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold_cnt;
      w_rep_nxt    = r_rep_cnt;
      w_long_nxt   = 1'b0;
      w_repeat_nxt = 1'b0;
      case (r_state)
         HOLD_IDLE: begin
            if (w_press) begin
               w_state_nxt = HOLD_HELD;
               w_hold_nxt  = '0;
            end
         end
         HOLD_HELD: begin
            if (w_release) begin
               w_state_nxt = HOLD_IDLE;
               w_hold_nxt  = '0;
            end else if (r_hold_cnt == HW'(LONG_CYC - 1)) begin
               w_state_nxt = HOLD_REPEAT;
               w_long_nxt  = 1'b1;
               w_rep_nxt   = '0;
            end else begin
               w_hold_nxt = r_hold_cnt + HW'(1);
            end
         end
         HOLD_REPEAT: begin
            if (w_release) begin
               w_state_nxt = HOLD_IDLE;
               w_hold_nxt  = '0;
               w_rep_nxt   = '0;
            end else if (r_rep_cnt == RW'(REPEAT_CYC - 1)) begin
               w_repeat_nxt = 1'b1;
               w_rep_nxt    = '0;
            end else begin
               w_rep_nxt = r_rep_cnt + RW'(1);
            end
         end
         default: begin
            w_state_nxt = HOLD_IDLE;
            w_hold_nxt  = '0;
            w_rep_nxt   = '0;
         end
      endcase
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;
   assign o_repeat  = r_repeat;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and classifies all board push-buttons.
// Ports:
//   clk, reset   clock and synchronous active-low reset
//   btn_raw      raw active-low pins, one bit per button
//   btn_level    debounced active-low levels, idle all ones
//   btn_press    one-cycle press pulses
//   btn_release  one-cycle release pulses
//   btn_long     one-cycle long-press pulses
//   btn_repeat   one-cycle auto-repeat pulses
module btn_conditioner
   import clock_pkg::*;
#(
   parameter int N_BTN        = 4,
   parameter int DEBOUNCE_CYC = DEBOUNCE_10MS,
   parameter int LONG_CYC     = LONG_1S,
   parameter int REPEAT_CYC   = REPEAT_200MS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long,
   output logic [N_BTN-1:0] btn_repeat
);
   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .LONG_CYC     (LONG_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_raw     (btn_raw[g]),
         .o_level   (btn_level[g]),
         .o_press   (btn_press[g]),
         .o_release (btn_release[g]),
         .o_long    (btn_long[g]),
         .o_repeat  (btn_repeat[g])
      );
   end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and randomized checks of btn_conditioner against a window-based reference model.
module tb_btn_conditioner;
   localparam int N  = 4;
   localparam int DB = 4;
   localparam int LG = 10;
   localparam int RP = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] btn_raw = '1;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;

   int total = 0;
   int bad = 0;
   int edge_n = 0;

   logic [N-1:0] samp [7];
   logic [N-1:0] m_level = '1, m_press = '0, m_rel = '0, m_long = '0, m_rep = '0;
   int           press_edge [N];

   always #5 clk = ~clk;

   btn_conditioner #(
      .N_BTN        (N),
      .DEBOUNCE_CYC (DB),
      .LONG_CYC     (LG),
      .REPEAT_CYC   (RP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long),
      .btn_repeat  (btn_repeat)
   );

   // A level flips once the last DB+1 raw samples, seen through the two-cycle
   // synchroniser delay, all disagree with it. Long/repeat pulses are simple
   // arithmetic on the distance from the press edge.
   task automatic model_step();
      logic stable;
      int   d;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      m_rep   = '0;
      if (!reset) begin
         for (int i = 0; i < 7; i++) samp[i] = '1;
         m_level = '1;
         for (int c = 0; c < N; c++) press_edge[c] = -1;
      end else begin
         for (int i = 6; i > 0; i--) samp[i] = samp[i-1];
         samp[0] = btn_raw;
         for (int c = 0; c < N; c++) begin
            stable = 1'b1;
            for (int i = 2; i <= DB + 2; i++) if (samp[i][c] == m_level[c]) stable = 1'b0;
            if (stable) begin
               m_level[c] = ~m_level[c];
               if (!m_level[c]) begin
                  m_press[c]    = 1'b1;
                  press_edge[c] = edge_n;
               end else begin
                  m_rel[c]      = 1'b1;
                  press_edge[c] = -1;
               end
            end else if (press_edge[c] >= 0) begin
               d = edge_n - press_edge[c];
               if (d == LG) m_long[c] = 1'b1;
               else if (d > LG && (d - LG) % RP == 0) m_rep[c] = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      edge_n++;
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      btn_raw = '0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {4'hF, 16'h0}) begin
            bad++;
            $display("FAIL reset edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {4'hF, 16'h0});
         end
      end
      reset   = 1'b1;
      btn_raw = '1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
            bad++;
            $display("FAIL reset_exit edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
         end
      end
   endtask

   task automatic test_press();
      int t, p_edge, p_cnt;
      p_edge = -1;
      p_cnt  = 0;
      btn_raw = 4'b0111;
      t = edge_n + 1;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (btn_press[3]) begin
            p_cnt++;
            if (p_edge < 0) p_edge = edge_n;
         end
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
            bad++;
            $display("FAIL press edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
         end
      end
      total++;
      if (p_edge !== t + 6 || p_cnt !== 1) begin
         bad++;
         $display("FAIL press_latency got edge=%0d count=%0d exp edge=%0d count=1", p_edge, p_cnt, t + 6);
      end
      btn_raw = '1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
            bad++;
            $display("FAIL press_rel edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
         end
      end
   endtask

   task automatic test_bounce();
      logic [6:0] pat;
      int t, p_edge, p_cnt;
      pat    = 7'b1000100;
      p_edge = -1;
      p_cnt  = 0;
      for (int k = 0; k < 17; k++) begin
         btn_raw[3] = (k < 7) ? pat[k] : 1'b0;
         if (k == 7) t = edge_n + 1;
         cycle();
         if (btn_press[3]) begin
            p_cnt++;
            if (p_edge < 0) p_edge = edge_n;
         end
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
            bad++;
            $display("FAIL bounce edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
         end
      end
      total++;
      if (p_edge !== t + 6 || p_cnt !== 1) begin
         bad++;
         $display("FAIL bounce_press got edge=%0d count=%0d exp edge=%0d count=1", p_edge, p_cnt, t + 6);
      end
      btn_raw = '1;
      for (int k = 0; k < 10; k++) cycle();
   endtask

   task automatic test_glitch();
      logic [4*N-1:0] act;
      logic           lvl_low;
      act     = '0;
      lvl_low = 1'b0;
      for (int k = 0; k < 14; k++) begin
         btn_raw[0] = (k < 3) ? 1'b0 : 1'b1;
         cycle();
         act     |= {btn_press, btn_release, btn_long, btn_repeat};
         lvl_low |= ~btn_level[0];
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
            bad++;
            $display("FAIL glitch edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
         end
      end
      total++;
      if (act !== '0 || lvl_low !== 1'b0) begin
         bad++;
         $display("FAIL glitch_quiet got pulses=%h level0_low=%b exp pulses=0 level0_low=0", act, lvl_low);
      end
   endtask

   task automatic test_hold();
      int p, r, l_edge, rel_edge, n_rep, rep_after;
      int rep_e [3];
      p = -1; l_edge = -1; rel_edge = -1; n_rep = 0; rep_after = 0;
      for (int i = 0; i < 3; i++) rep_e[i] = -1;
      btn_raw[3] = 1'b0;
      for (int k = 0; k < 20 && p < 0; k++) begin
         cycle();
         if (btn_press[3]) p = edge_n;
      end
      total++;
      if (p < 0) begin
         bad++;
         $display("FAIL hold_press got none exp pulse within 20 cycles");
      end else begin
         while (edge_n < p + 20) begin
            cycle();
            if (btn_long[3] && l_edge < 0) l_edge = edge_n;
            if (btn_repeat[3]) begin
               if (n_rep < 3) rep_e[n_rep] = edge_n;
               n_rep++;
            end
            total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
               bad++;
               $display("FAIL hold edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
            end
         end
         total++;
         if (l_edge !== p + 10) begin
            bad++;
            $display("FAIL hold_long got=%0d exp=%0d", l_edge, p + 10);
         end
         total++;
         if (rep_e[0] !== p + 13 || rep_e[1] !== p + 16 || rep_e[2] !== p + 19) begin
            bad++;
            $display("FAIL hold_repeat got=%0d,%0d,%0d exp=%0d,%0d,%0d", rep_e[0], rep_e[1], rep_e[2], p + 13, p + 16, p + 19);
         end
         btn_raw[3] = 1'b1;
         r = edge_n + 1;
         for (int k = 0; k < 14; k++) begin
            cycle();
            if (btn_release[3] && rel_edge < 0) rel_edge = edge_n;
            if (btn_repeat[3] && rel_edge >= 0) rep_after++;
            total++;
            if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
               bad++;
               $display("FAIL hold_rel edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
            end
         end
         total++;
         if (rel_edge !== r + 6 || rep_after !== 0) begin
            bad++;
            $display("FAIL hold_release got edge=%0d repeats_after=%0d exp edge=%0d repeats_after=0", rel_edge, rep_after, r + 6);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      int p, d, p2, l2, n_rel;
      p = -1; p2 = -1; l2 = -1; n_rel = 0;
      btn_raw[1] = 1'b0;
      for (int k = 0; k < 20 && p < 0; k++) begin
         cycle();
         if (btn_press[1]) p = edge_n;
      end
      while (p >= 0 && edge_n < p + 14) cycle();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (btn_release[1]) n_rel++;
         total++;
         if ({btn_level[1], btn_press[1], btn_release[1], btn_long[1], btn_repeat[1]} !== 5'b10000) begin
            bad++;
            $display("FAIL midreset edge=%0d got=%b exp=10000", edge_n, {btn_level[1], btn_press[1], btn_release[1], btn_long[1], btn_repeat[1]});
         end
      end
      reset = 1'b1;
      d = edge_n + 1;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (btn_release[1]) n_rel++;
         if (btn_press[1] && p2 < 0) p2 = edge_n;
         if (btn_long[1] && l2 < 0) l2 = edge_n;
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
            bad++;
            $display("FAIL midreset_after edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
         end
      end
      total++;
      if (p2 !== d + 6 || l2 !== d + 16 || n_rel !== 0) begin
         bad++;
         $display("FAIL midreset_repress got press=%0d long=%0d releases=%0d exp press=%0d long=%0d releases=0", p2, l2, n_rel, d + 6, d + 16);
      end
      btn_raw = '1;
      for (int k = 0; k < 10; k++) cycle();
   endtask

   task automatic test_random();
      int run [N];
      for (int c = 0; c < N; c++) run[c] = 1;
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < N; c++) begin
            run[c]--;
            if (run[c] <= 0) begin
               btn_raw[c] = ~btn_raw[c];
               run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 7);
            end
         end
         reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         cycle();
         total++;
         if ({btn_level, btn_press, btn_release, btn_long, btn_repeat} !== {m_level, m_press, m_rel, m_long, m_rep}) begin
            bad++;
            $display("FAIL random edge=%0d got=%h exp=%h", edge_n, {btn_level, btn_press, btn_release, btn_long, btn_repeat}, {m_level, m_press, m_rel, m_long, m_rep});
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_glitch();
      test_hold();
      test_reset_mid_hold();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
